// File: rtl/led_status_display.sv
// led_status_display: slow step-driven LED patterns (rotate, bounce, value,
// blink) with a sticky alarm blink overlay; all outputs registered.
// Ports: i_clk, i_reset (sync, active-high), i_mode[1:0], i_value,
//   i_value_valid, i_alarm, i_alarm_clr -> o_led, o_heartbeat, o_step, o_alarm.
module led_status_display #(
   parameter int N_LEDS         = 4,
   parameter int DIV_BITS       = 16,
   parameter int TICKS_PER_STEP = 32
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic [1:0]        i_mode,
   input  logic [N_LEDS-1:0] i_value,
   input  logic              i_value_valid,
   input  logic              i_alarm,
   input  logic              i_alarm_clr,
   output logic [N_LEDS-1:0] o_led,
   output logic              o_heartbeat,
   output logic              o_step,
   output logic              o_alarm
);

   localparam int PW = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;
   localparam int TW = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
   localparam logic [PW-1:0] POS_MAX  = PW'(N_LEDS - 1);
   localparam logic [TW-1:0] TICK_MAX = TW'(TICKS_PER_STEP - 1);

   typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

   logic [DIV_BITS-1:0] r_div_cnt;
   logic [TW-1:0]       r_tick_cnt;
   logic [1:0]          r_mode;
   logic [PW-1:0]       r_pos;
   dir_t                r_dir;
   logic [N_LEDS-1:0]   r_val;
   logic                r_alarm;
   logic                r_hb;
   logic                r_step;
   logic [N_LEDS-1:0]   r_led;
   logic                r_alarm_o;

   logic                w_tick;
   logic                w_step;
   logic                w_mode_chg;
   logic [PW-1:0]       w_pos_nxt;
   dir_t                w_dir_nxt;
   logic [N_LEDS-1:0]   w_led_nxt;

   assign w_tick     = &r_div_cnt;
   assign w_step     = w_tick && (r_tick_cnt == TICK_MAX);
   assign w_mode_chg = (i_mode != r_mode);

   // position / direction next state; a mode change restarts the pattern
   // and suppresses any advance on the same edge
   always_comb begin
      w_pos_nxt = r_pos;
      w_dir_nxt = r_dir;
      if (w_mode_chg) begin
         w_pos_nxt = '0;
         w_dir_nxt = DIR_UP;
      end else if (w_step) begin
         if (r_mode == 2'd1) begin
            if (N_LEDS > 1) begin
               if (r_dir == DIR_UP) begin
                  if (r_pos == POS_MAX) begin
                     w_pos_nxt = r_pos - 1'b1;
                     w_dir_nxt = DIR_DOWN;
                  end else begin
                     w_pos_nxt = r_pos + 1'b1;
                  end
               end else begin
                  if (r_pos == '0) begin
                     w_pos_nxt = r_pos + 1'b1;
                     w_dir_nxt = DIR_UP;
                  end else begin
                     w_pos_nxt = r_pos - 1'b1;
                  end
               end
            end
         end else begin
            w_pos_nxt = (r_pos == POS_MAX) ? '0 : r_pos + 1'b1;
         end
      end
   end

   // LED pattern from the registered state; alarm overrides every mode
   always_comb begin
      w_led_nxt = '0;
      if (r_alarm) begin
         w_led_nxt = {N_LEDS{r_hb}};
      end else begin
         unique case (r_mode)
            2'd0:    w_led_nxt = N_LEDS'(1) << r_pos;
            2'd1:    w_led_nxt = N_LEDS'(1) << r_pos;
            2'd2:    w_led_nxt = r_val;
            default: w_led_nxt = {N_LEDS{r_hb}};
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_div_cnt  <= '0;
         r_tick_cnt <= '0;
         r_mode     <= 2'd0;
         r_pos      <= '0;
         r_dir      <= DIR_UP;
         r_val      <= '0;
         r_alarm    <= 1'b0;
         r_hb       <= 1'b0;
         r_step     <= 1'b0;
         r_led      <= '0;
         r_alarm_o  <= 1'b0;
      end else begin
         r_div_cnt <= r_div_cnt + 1'b1;
         if (w_tick) begin
            r_tick_cnt <= (r_tick_cnt == TICK_MAX) ? '0 : r_tick_cnt + 1'b1;
         end
         r_mode <= i_mode;
         r_pos  <= w_pos_nxt;
         r_dir  <= w_dir_nxt;
         if (i_value_valid) begin
            r_val <= i_value;
         end
         // set has priority over clear
         if (i_alarm) begin
            r_alarm <= 1'b1;
         end else if (i_alarm_clr) begin
            r_alarm <= 1'b0;
         end
         if (w_step) begin
            r_hb <= ~r_hb;
         end
         r_step    <= w_step;
         r_led     <= w_led_nxt;
         r_alarm_o <= r_alarm;
      end
   end

   assign o_led       = r_led;
   assign o_heartbeat = r_hb;
   assign o_step      = r_step;
   assign o_alarm     = r_alarm_o;

endmodule
